// File: rtl/iic_xfer_seq.sv
// Register-style I2C transaction sequencer. It feeds iic_core's TX FIFO with the
// address/register/data byte stream and collects read bytes from its RX FIFO.
module iic_xfer_seq #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [2:0]  nbytes,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        tx_fifo_wr,
    output logic [7:0]  tx_fifo_din,
    input  logic        tx_fifo_full,
    output logic        rx_fifo_rd,
    input  logic [7:0]  rx_fifo_dout,
    input  logic        rx_fifo_empty
);

    typedef enum logic [2:0] {
        IDLE, PUSH_WADDR, PUSH_REG, PUSH_DATA, PUSH_RADDR, WAIT_RX, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             rnw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [31:0]      wdata_q;
    logic [2:0]       len_q, len_in, idx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             push_req, push_ok, pop, tmo_hit;
    logic [7:0]       push_byte;

    // Out-of-range byte counts are clamped into 1..4.
    always_comb begin
        if (nbytes == 3'd0)      len_in = 3'd1;
        else if (nbytes > 3'd4)  len_in = 3'd4;
        else                     len_in = nbytes;
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_byte = 8'h00;
        pop       = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:       if (start) state_nxt = PUSH_WADDR;
            PUSH_WADDR: begin
                push_req  = 1'b1;
                push_byte = {dev_q, 1'b0};
                if (!tx_fifo_full) state_nxt = PUSH_REG;
            end
            PUSH_REG: begin
                push_req  = 1'b1;
                push_byte = reg_q;
                if (!tx_fifo_full) state_nxt = rnw_q ? PUSH_RADDR : PUSH_DATA;
            end
            PUSH_DATA: begin
                // The extra pass with idx == len_q lets the last registered write
                // show on the bus before done.
                if (idx == len_q) begin
                    state_nxt = DONE;
                end else begin
                    push_req  = 1'b1;
                    push_byte = wdata_q[{idx[1:0], 3'b000} +: 8];
                end
            end
            PUSH_RADDR: begin
                push_req  = 1'b1;
                push_byte = {dev_q, 1'b1};
                if (!tx_fifo_full) state_nxt = WAIT_RX;
            end
            WAIT_RX: begin
                if (!rx_fifo_empty && idx != len_q) begin
                    pop = 1'b1;
                    if (idx == len_q - 3'd1) state_nxt = DONE;
                end else if (rx_fifo_empty && tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign push_ok    = push_req && !tx_fifo_full;
    assign rx_fifo_rd = pop;
    assign done       = (state == DONE);
    assign busy       = (state != IDLE) && (state != DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_fifo_wr  <= 1'b0;
            tx_fifo_din <= 8'h00;
            err         <= 1'b0;
            rd_data     <= 32'h0;
            idx         <= 3'd0;
            tmo_cnt     <= '0;
            rnw_q       <= 1'b0;
            dev_q       <= 7'h0;
            reg_q       <= 8'h0;
            wdata_q     <= 32'h0;
            len_q       <= 3'd1;
        end else begin
            state      <= state_nxt;
            tx_fifo_wr <= push_ok;
            if (push_ok) tx_fifo_din <= push_byte;

            if (state == IDLE && start) begin
                rnw_q   <= rnw;
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                wdata_q <= wr_data;
                len_q   <= len_in;
                idx     <= 3'd0;
                err     <= 1'b0;
                rd_data <= 32'h0;
            end

            if (state == PUSH_DATA && push_ok) idx <= idx + 3'd1;

            if (pop) begin
                rd_data[{idx[1:0], 3'b000} +: 8] <= rx_fifo_dout;
                idx <= idx + 3'd1;
            end

            // Loaded with 1 so done lands exactly TIMEOUT_CYCLES cycles after the
            // last pop (or after the cycle the read address was pushed).
            if (state != WAIT_RX || pop) tmo_cnt <= CNT_W'(1);
            else                         tmo_cnt <= tmo_cnt + CNT_W'(1);

            if (tmo_hit) err <= 1'b1;
        end
    end

endmodule

// File: doc/iic_xfer_seq.md
Name: iic_xfer_seq

Overview:
Transaction sequencer directly upstream of iic_core. It turns a single register-style request (7-bit device address, 8-bit register address, read/write, 1-4 data bytes) into the byte stream for iic_core's TX FIFO. For reads, it drains the expected bytes from iic_core's RX FIFO and assembles them into a 32-bit word. It reports completion, busy and timeout status to the control/status register logic.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed in WAIT_RX without an RX byte before aborting with err.
CNT_W, 17, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  request strobe, sampled only in IDLE
rnw  in  1  1 = read, 0 = write
dev_addr  in  7  I2C device address
reg_addr  in  8  register address byte
nbytes  in  3  data byte count, legal 1..4
wr_data  in  32  write payload, byte 0 = bits[7:0], sent first
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  status for the last transaction, valid with done, held until the next accepted start
rd_data  out  32  read result, byte 0 in bits[7:0], unused upper bytes zero
tx_fifo_wr  out  1  iic_core TX FIFO write
tx_fifo_din  out  8  iic_core TX FIFO data
tx_fifo_full  in  1  iic_core TX FIFO full
rx_fifo_rd  out  1  iic_core RX FIFO pop (first-word-fall-through)
rx_fifo_dout  in  8  iic_core RX FIFO head data, valid while !rx_fifo_empty
rx_fifo_empty  in  1  iic_core RX FIFO empty

Behaviour:
- Reset values (on reset, also mid-transaction):
  - state = IDLE; busy, done, err, tx_fifo_wr and rx_fifo_rd all 0; tx_fifo_din = 0; rd_data = 0.
  - No partial byte is pushed after reset. Bytes already in iic_core are not recalled.
- Request capture:
  - start is accepted only in IDLE. On acceptance, rnw, dev_addr, reg_addr, wr_data and nbytes are latched, and err and rd_data are cleared.
  - start outside IDLE is ignored.
  - nbytes = 0 is treated as 1; nbytes 5..7 is treated as 4.
- States:
  - IDLE -> PUSH_WADDR on start.
  - PUSH_WADDR pushes {dev_addr,1'b0}, then PUSH_REG.
  - PUSH_REG pushes reg_addr. Next state is PUSH_RADDR if rnw = 1, else PUSH_DATA.
  - PUSH_DATA pushes wr_data bytes 0..nbytes-1. After the last byte, DONE.
  - PUSH_RADDR pushes {dev_addr,1'b1}, then WAIT_RX.
  - WAIT_RX pops nbytes bytes, then DONE.
  - DONE asserts done for one cycle, then IDLE.
- Push rule:
  - tx_fifo_wr and tx_fifo_din are registered outputs.
  - A byte is written (tx_fifo_wr = 1 for exactly one cycle) only in a cycle where tx_fifo_full is sampled 0. If full, the state machine stalls with tx_fifo_wr = 0.
  - Maximum rate is one byte per clk.
  - Byte order is strictly as listed; no byte is skipped or duplicated.
- Pop rule:
  - In WAIT_RX, rx_fifo_rd = rx_fifo_empty ? 0 : 1 (combinational on empty, gated by state and remaining count).
  - In the same cycle, rx_fifo_dout is captured into rd_data byte lane k, where k = bytes received so far (0..3).
  - Exactly nbytes pops per read; no extra pop after the last byte.
- Timeout:
  - The counter resets on entry to WAIT_RX and on every pop, and increments each WAIT_RX cycle with the FIFO empty.
  - When the count reaches TIMEOUT_CYCLES: err = 1, then DONE. Bytes already captured remain in rd_data.
- Latency:
  - A write with nbytes = N and TX never full takes 2+N push cycles. done rises on the cycle after the last tx_fifo_wr.
  - For a read, done rises on the cycle after the last rx_fifo_rd.
- busy is high in every state except IDLE and is low in the cycle done is high.

Test Plan:
- Write, 0x50 / reg 0x10 / nbytes 2 / wr_data 0x0000BEEF, TX never full -> tx_fifo_din sequence A0, 10, EF, BE on 4 consecutive wr cycles; done on the next cycle; err = 0.
- Same write with tx_fifo_full held high for cycles 2-6 after start -> no wr while full; the same 4-byte sequence is completed with no duplicates.
- Read, 0x68 / reg 0x3B / nbytes 3; bench loads RX FIFO with 12, 34, 56 at 5-cycle spacing -> TX bytes D0, 3B, D1; exactly 3 pops; rd_data = 0x00563412; err = 0.
- Read, nbytes 2, TIMEOUT_CYCLES = 50; bench supplies only 0xAA -> done exactly 50 cycles after the pop; err = 1; rd_data = 0x000000AA.
- start pulsed again while busy -> ignored; the first transaction's byte stream is unchanged.
- reset asserted during PUSH_DATA -> next cycle all outputs at reset values and state IDLE; a new start then runs a correct full sequence.
